// File: rtl/vga_vram_arbiter.sv
// Framebuffer RAM arbiter: bursts one display line into a ping-pong line buffer
// on each line_start, while reserving periodic slots for a pixel writer.
module vga_vram_arbiter #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1,
  parameter int WR_EVERY = 8
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [9:0]        line_num,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [9:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_busy,
  output logic              overrun,
  output logic              wr_err
);

  localparam int CYC_W = $clog2(WR_EVERY + 1);
  localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [9:0]        LINE_LIMIT = 10'(V_ACTIVE);
  localparam logic [9:0]        LAST_PIX   = 10'(H_ACTIVE - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC   = CYC_W'(WR_EVERY - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] pix;
  } rd_tag_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [9:0]        pix_q;
  logic [CYC_W-1:0]  cyc_q;
  logic              bank_q;
  rd_tag_t           pipe_q [RD_LAT];

  logic start;
  logic rd_slot;
  logic wr_grant;
  logic drain_done;
  logic in_range;

  // Only the stages before the output matter: the last stage drains this cycle.
  always_comb begin
    drain_done = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (pipe_q[i].valid) drain_done = 1'b0;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    rd_slot  = 1'b0;
    wr_grant = 1'b0;
    overrun  = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start && line_num < LINE_LIMIT) begin
          start   = 1'b1;
          state_d = FETCH;
        end else begin
          wr_grant = wr_valid;
        end
      end
      FETCH: begin
        overrun = line_start;
        if (cyc_q == LAST_CYC && wr_valid) begin
          wr_grant = 1'b1;
        end else begin
          rd_slot = 1'b1;
          if (pix_q == LAST_PIX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        overrun  = line_start;
        wr_grant = wr_valid;
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A cycle spent in reset never grants, reads or flags anything.
    if (!reset_n) begin
      start    = 1'b0;
      rd_slot  = 1'b0;
      wr_grant = 1'b0;
      overrun  = 1'b0;
    end

    in_range  = wr_addr < PIX_LIMIT;
    wr_ready  = wr_grant;
    ram_we    = wr_grant && in_range;
    wr_err    = wr_grant && !in_range;
    ram_wdata = wr_grant ? wr_data : '0;
    if (rd_slot)       ram_addr = base_q + ADDR_W'(pix_q);
    else if (wr_grant) ram_addr = wr_addr;
    else               ram_addr = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      base_q <= '0;
      pix_q  <= '0;
      cyc_q  <= '0;
      bank_q <= 1'b0;
      // NOTE: the read-tag pipeline is a short register chain, not a RAM, so it
      // is reset; that guarantees no stale lb_we escapes after an aborted burst.
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      if (start) begin
        base_q <= ADDR_W'(line_num) * ADDR_W'(H_ACTIVE);
        pix_q  <= '0;
        cyc_q  <= '0;
        bank_q <= ~bank_q;
      end else if (state_q == FETCH) begin
        cyc_q <= (cyc_q == LAST_CYC) ? '0 : cyc_q + CYC_W'(1);
        if (rd_slot) pix_q <= pix_q + 10'd1;
      end
      pipe_q[0] <= '{valid: rd_slot, pix: pix_q};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign lb_we      = pipe_q[RD_LAT-1].valid;
  assign lb_addr    = pipe_q[RD_LAT-1].pix;
  assign lb_wdata   = lb_we ? ram_rdata : '0;
  assign lb_bank    = bank_q;
  assign fetch_busy = (state_q != IDLE);

endmodule
